// File: rtl/demux_writeback_if.sv
// rtl/demux_writeback_if.sv - result-word handshake bundle for demux_writeback
interface demux_writeback_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic [1:0]       D;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output D,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  D,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/demux_writeback.sv
// rtl/demux_writeback.sv - 2-entry buffered demux of result words into four destination registers
module demux_writeback #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  demux_writeback_if.slave    bus,
  input  logic                hold,
  input  logic                clear_flags,
  output logic [WIDTH-1:0]    out1,
  output logic [WIDTH-1:0]    out2,
  output logic [WIDTH-1:0]    out3,
  output logic [WIDTH-1:0]    out4,
  output logic [3:0]          wr_flag,
  output logic                all_written,
  output logic                done,
  output logic                ovw
);

  logic [WIDTH-1:0] fifo_data [2];
  logic [1:0]       fifo_d    [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  logic             accept;
  logic             commit;
  logic [WIDTH-1:0] head_data;
  logic [1:0]       head_d;
  logic [3:0]       flag_next;
  logic             ovw_next;

  // Ready depends only on occupancy, so a same-edge commit never frees a slot early.
  assign bus.in_ready = (count != 2'd2);
  assign accept       = bus.in_valid & bus.in_ready;
  assign commit       = (count != 2'd0) & ~hold;
  assign head_data    = fifo_data[rd_ptr];
  assign head_d       = fifo_d[rd_ptr];
  assign all_written  = &wr_flag;

  // Clear is applied before the commit, so a same-edge commit keeps its flag and never flags ovw.
  always_comb begin
    flag_next = clear_flags ? 4'b0000 : wr_flag;
    ovw_next  = clear_flags ? 1'b0 : ovw;
    if (commit) begin
      if (flag_next[head_d]) begin
        ovw_next = 1'b1;
      end
      flag_next[head_d] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_data[wr_ptr] <= bus.in_data;
      fifo_d[wr_ptr]    <= bus.D;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= 2'd0;
      out1    <= '0;
      out2    <= '0;
      out3    <= '0;
      out4    <= '0;
      wr_flag <= 4'b0000;
      ovw     <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= ~wr_ptr;
      end
      if (commit) begin
        rd_ptr <= ~rd_ptr;
        case (head_d)
          2'd0:    out1 <= head_data;
          2'd1:    out2 <= head_data;
          2'd2:    out3 <= head_data;
          default: out4 <= head_data;
        endcase
      end
      case ({accept, commit})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      wr_flag <= flag_next;
      ovw     <= ovw_next;
      done    <= (&flag_next) & ~(&wr_flag);
    end
  end

endmodule
